// File: rtl/calc_sequencer.sv
// Calculator operation sequencer: captures A then B/op on enter pulses,
// runs add/sub in one cycle or multiply as a WIDTH-cycle shift-add, and
// presents a registered result with busy/valid/error status.
module calc_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_enter,
  input  logic                 btn_clear,
  input  logic [1:0]           op_sel,
  input  logic [WIDTH-1:0]     sw_data,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   result,
  output logic                 neg,
  output logic                 result_valid,
  output logic                 err,
  output logic [2:0]           state_code
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT_B = 3'd1,
    S_EXEC   = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b;
  logic [1:0]       r_op;
  logic [RW-1:0]    r_acc, r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_neg;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_a_ge_b;
  logic [RW-1:0]    w_acc_nxt;
  logic             w_mul_last;

  // Datapath arithmetic for the EXEC state, shared by next-state and registers.
  always_comb begin
    w_sum      = {1'b0, r_a} + {1'b0, r_b};
    w_a_ge_b   = (r_a >= r_b);
    w_diff     = w_a_ge_b ? (r_a - r_b) : (r_b - r_a);
    w_acc_nxt  = r_acc + (r_b[r_cnt] ? (RW'(r_a) << r_cnt) : '0);
    w_mul_last = (r_cnt == CW'(WIDTH - 1));
  end

  // State register; reset behaves exactly like clear.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; clear has priority over enter in every state.
  always_comb begin
    w_state_nxt = r_state;
    if (btn_clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (btn_enter) w_state_nxt = S_WAIT_B;
        S_WAIT_B: if (btn_enter) w_state_nxt = (op_sel == OP_RSV) ? S_ERR : S_EXEC;
        S_EXEC: begin
          if (r_op == OP_MUL) begin
            if (w_mul_last) w_state_nxt = S_DONE;
          end else if (r_op == OP_RSV) begin
            w_state_nxt = S_ERR;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
        S_DONE:   if (btn_enter) w_state_nxt = S_WAIT_B;
        S_ERR:    w_state_nxt = S_ERR;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Operand capture, multiply accumulation and result registers.
  always_ff @(posedge clk) begin
    if (rst || btn_clear) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_neg    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (btn_enter) r_a <= sw_data;
        S_WAIT_B: if (btn_enter) begin
          r_b   <= sw_data;
          r_op  <= op_sel;
          r_acc <= '0;
          r_cnt <= '0;
        end
        S_EXEC: begin
          case (r_op)
            OP_ADD: begin
              r_result <= RW'(w_sum);
              r_neg    <= 1'b0;
            end
            OP_SUB: begin
              r_result <= RW'(w_diff);
              r_neg    <= ~w_a_ge_b;
            end
            OP_MUL: begin
              r_acc <= w_acc_nxt;
              r_cnt <= r_cnt + CW'(1);
              r_neg <= 1'b0;
              if (w_mul_last) r_result <= w_acc_nxt;
            end
            default: r_result <= '0;
          endcase
        end
        // Leaving DONE starts a fresh calculation with A from the switches.
        S_DONE: if (btn_enter) begin
          r_a      <= sw_data;
          r_result <= '0;
          r_neg    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Status outputs decode straight from the state register.
  always_comb begin
    busy         = (r_state == S_EXEC);
    result_valid = (r_state == S_DONE);
    err          = (r_state == S_ERR);
    result       = err ? '0 : r_result;
    neg          = r_neg;
    state_code   = r_state;
  end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Operation controller for the push-button calculator. It captures two operands from the switch bank on successive enter pulses, latches the selected operation, and sequences execution. Add and subtract run in one cycle; multiply runs as an iterative shift-add. It presents a registered result with valid/busy/error status to the LED decoder and scan path. It replaces the free-running select-by-control multiplexing of the adder and multiplier results.

## Interface
- WIDTH, 4, operand width in bits
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- btn_enter  input  1  single-cycle pulse from the button detector; advances the sequence
- btn_clear  input  1  single-cycle pulse; aborts to idle from any state
- op_sel  input  2  operation, sampled with operand B: 00 add, 01 subtract, 10 multiply, 11 reserved
- sw_data  input  WIDTH  operand value, sampled on enter
- busy  output  1  high while in EXEC
- result  output  2*WIDTH  unsigned result magnitude
- neg  output  1  subtract result is negative
- result_valid  output  1  high while in DONE
- err  output  1  high while in ERR
- state_code  output  3  current state encoding, for LED display

## Operation
- States and encodings: IDLE=0, WAIT_B=1, EXEC=2, DONE=3, ERR=4.
- IDLE, on enter:
  - A <= sw_data.
  - Go to WAIT_B.
- WAIT_B, on enter:
  - B <= sw_data and op <= op_sel.
  - If op_sel=11, go to ERR. Otherwise go to EXEC, with accumulator cleared and cnt=0.
- EXEC, add:
  - result <= A+B, zero-extended to 2*WIDTH. Maximum value is 2^(WIDTH+1)-2; no overflow.
  - neg <= 0.
  - Go to DONE after 1 cycle.
- EXEC, subtract:
  - If A>=B: result <= A-B and neg <= 0.
  - Otherwise: result <= B-A and neg <= 1.
  - Go to DONE after 1 cycle.
- EXEC, multiply:
  - Each cycle k = 0..WIDTH-1: acc <= acc + (B[k] ? A<<k : 0).
  - cnt increments each cycle. On the cycle with cnt=WIDTH-1, result <= the final sum and the FSM goes to DONE.
  - neg <= 0. Maximum value is (2^WIDTH-1)^2; no overflow.
- DONE:
  - result, neg and result_valid are held.
  - On enter: A <= sw_data, result_valid drops, go to WAIT_B. This starts a new calculation.
- ERR:
  - err=1 and result=0.
  - enter is ignored. Only clear exits.
- Clear in any state:
  - Next state is IDLE.
  - A, B, op, acc, cnt, result, neg all go to 0.
- enter during EXEC is ignored and is not queued.
- Simultaneous clear and enter: clear wins.
- Reset in the middle of an operation behaves identically to clear.
- Operands are not re-sampled during EXEC. Changing sw_data or op_sel mid-operation has no effect.

## Timing
- Reset values:
  - state IDLE, state_code=0.
  - busy=0, result_valid=0, err=0, neg=0, result=0.
- All outputs are registered or decoded directly from the state register. There is no combinational path from inputs to outputs.
- Let enter be accepted in WAIT_B at edge t:
  - busy=1 from t+1.
  - Add/subtract: result and result_valid are visible after edge t+2 (1 EXEC cycle).
  - Multiply: result and result_valid are visible after edge t+1+WIDTH, i.e. 5 cycles for WIDTH=4.
  - Reserved op: err=1 after edge t+1; busy stays 0.
- result holds its value until the next DONE-exit enter, clear, or reset.
- The enter pulse is assumed one cycle wide. A held-high level would advance one state per cycle, so the upstream detector must guarantee single-cycle pulses.

## Test plan
- Add:
  - Stimulus: A=7, B=9, op=00.
  - Response: result=16, neg=0. result_valid rises exactly 2 cycles after B's enter; busy high for 1 cycle.
- Subtract:
  - Stimulus: A=3, B=5, op=01.
  - Response: result=2, neg=1.
  - Repeat with A=5, B=3. Response: result=2, neg=0.
- Multiply:
  - Stimulus: A=15, B=15, op=10.
  - Response: result=225. busy high for exactly 4 cycles; result_valid at t+5.
  - Repeat with A=0, B=13. Response: result=0.
- Reserved op:
  - Stimulus: A=4, B=4, op=11.
  - Response: err=1, state_code=4. A further enter leaves err=1. Clear returns to state_code=0 with err=0.
- Clear mid-multiply:
  - Stimulus: assert clear on the 2nd EXEC cycle.
  - Response: next cycle state_code=0, busy=0, result=0. An enter pulse in the same cycle as clear does not capture A.
- Enter while busy, and restart from DONE:
  - Stimulus: enter during EXEC.
  - Response: ignored, and the result is unchanged from the no-enter run.
  - Stimulus: enter in DONE with sw_data=6.
  - Response: A=6, state_code=1, result_valid=0.
